// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the seven-segment writeback display:
//   - conversion FSM state encoding
//   - digit/group geometry and operand widths
//   - active-low segment codes {a,b,c,d,e,f,g} (bit 6 = a)
//   - helpers for segment decode and the double-dabble adjust step
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } convState_t;

  localparam int NUM_DIGITS       = 8;
  localparam int DIGITS_PER_GROUP = 4;
  localparam int VALUE_WIDTH      = 13;
  localparam int SHIFT_CYCLES     = 13;
  localparam int BCD_WIDTH        = 4 * DIGITS_PER_GROUP;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles cannot come out of the converter; they blank
  // rather than show garbage.
  function automatic logic [6:0] segDecode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Add 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_WIDTH-1:0] dabbleAdjust(input logic [BCD_WIDTH-1:0] bcd);
    logic [BCD_WIDTH-1:0] adj;
    adj = bcd;
    for (int n = 0; n < DIGITS_PER_GROUP; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// bin2bcd_seq
// Sequential shift-add-3 converter: one 13-bit binary value to four BCD
// nibbles, one shift per clock, SHIFT_CYCLES clocks per conversion.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - capture value, clear the accumulator and begin shifting
//   value     - binary operand (sampled only on start)
//   done      - high during the cycle whose shift completes the conversion
//   bcd       - {thousands, hundreds, tens, units}; final after done cycle
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic                   done,
  output logic [BCD_WIDTH-1:0]   bcd
);

  logic [VALUE_WIDTH-1:0] binReg;
  logic [3:0]             stepCnt;
  logic                   active;
  logic [BCD_WIDTH-1:0]   bcdAdj;

  assign bcdAdj = dabbleAdjust(bcd);
  assign done   = active && (stepCnt == 4'(SHIFT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binReg  <= '0;
      bcd     <= '0;
      stepCnt <= '0;
      active  <= 1'b0;
    end else if (start) begin
      binReg  <= value;
      bcd     <= '0;
      stepCnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      // The adjusted top bit is always zero for a 13-bit operand, so
      // shifting it out loses nothing.
      bcd     <= (bcdAdj << 1) | BCD_WIDTH'(binReg[VALUE_WIDTH-1]);
      binReg  <= binReg << 1;
      stepCnt <= stepCnt + 4'd1;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display
// Shows two 13-bit writeback values in decimal on an 8-digit multiplexed
// seven-segment display. NumberA occupies digits 3..0, NumberB digits 7..4.
// Ports:
//   Clk, Rst  - board clock, asynchronous active-high reset
//   Load      - one-cycle strobe capturing NumberA/NumberB
//   NumberA/B - binary operands
//   Busy      - conversion in progress (registered)
//   out7      - active-low segments {a..g}, registered
//   en_out    - active-low digit anodes, registered, at most one low
//
// Conversion FSM
//   state  | meaning
//   IDLE   | displayed digits stable, waiting for Load
//   SHIFT  | both converters shifting, SHIFT_CYCLES cycles
//   COMMIT | copy BCD results to the display; restart if a load is waiting
module seg_scan_display
  import display_pkg::*;
#(
  parameter int REFRESH_BITS  = 17,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Load,
  input  logic [VALUE_WIDTH-1:0] NumberA,
  input  logic [VALUE_WIDTH-1:0] NumberB,
  output logic                   Busy,
  output logic [6:0]             out7,
  output logic [NUM_DIGITS-1:0]  en_out
);

  localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);
  localparam int NUM_GROUPS = NUM_DIGITS / DIGITS_PER_GROUP;

  convState_t             state;
  logic                   pendFlag;
  logic [VALUE_WIDTH-1:0] pendA;
  logic [VALUE_WIDTH-1:0] pendB;
  logic [3:0]             digitReg [NUM_DIGITS];

  logic                   startConv;
  logic [VALUE_WIDTH-1:0] opA;
  logic [VALUE_WIDTH-1:0] opB;
  logic [BCD_WIDTH-1:0]   bcdA;
  logic [BCD_WIDTH-1:0]   bcdB;
  logic                   doneA;
  logic                   doneB;

  logic [REFRESH_BITS-1:0] scanCnt;
  logic [2:0]              sel;
  logic [NUM_DIGITS-1:0]   blankMask;
  logic                    zeroAbove;

  // A Load arriving in COMMIT is newer than anything pending, so it is
  // started directly instead of the pending operands.
  always_comb begin
    startConv = 1'b0;
    opA       = NumberA;
    opB       = NumberB;
    case (state)
      IDLE: begin
        startConv = Load;
      end
      COMMIT: begin
        startConv = Load || pendFlag;
        if (!Load) begin
          opA = pendA;
          opB = pendB;
        end
      end
      default: begin
        startConv = 1'b0;
      end
    endcase
  end

  bin2bcd_seq u_convA (
    .clk   (Clk),
    .rst   (Rst),
    .start (startConv),
    .value (opA),
    .done  (doneA),
    .bcd   (bcdA)
  );

  bin2bcd_seq u_convB (
    .clk   (Clk),
    .rst   (Rst),
    .start (startConv),
    .value (opB),
    .done  (doneB),
    .bcd   (bcdB)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      pendFlag <= 1'b0;
      pendA    <= '0;
      pendB    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digitReg[i] <= 4'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (Load) begin
            state <= SHIFT;
            Busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (Load) begin
            pendA    <= NumberA;
            pendB    <= NumberB;
            pendFlag <= 1'b1;
          end
          if (doneA && doneB) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          for (int i = 0; i < DIGITS_PER_GROUP; i++) begin
            digitReg[i]                  <= bcdA[4*i +: 4];
            digitReg[i+DIGITS_PER_GROUP] <= bcdB[4*i +: 4];
          end
          pendFlag <= 1'b0;
          if (startConv) begin
            state <= SHIFT;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Leading-zero mask: walk each group from its most significant digit
  // down; the group's units digit is never blanked.
  always_comb begin
    blankMask = '0;
    zeroAbove = 1'b1;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      zeroAbove = 1'b1;
      for (int p = DIGITS_PER_GROUP - 1; p > 0; p--) begin
        zeroAbove = zeroAbove && (digitReg[g*DIGITS_PER_GROUP + p] == 4'd0);
        blankMask[g*DIGITS_PER_GROUP + p] = zeroAbove;
      end
    end
  end

  assign sel = scanCnt[REFRESH_BITS-1 -: 3];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scanCnt <= '0;
      en_out  <= '1;
      out7    <= SEG_BLANK;
    end else begin
      scanCnt <= scanCnt + REFRESH_BITS'(1);
      en_out  <= ~(ANODE_ONE << sel);
      if (BLANK_LEADING && blankMask[sel]) begin
        out7 <= SEG_BLANK;
      end else begin
        out7 <= segDecode(digitReg[sel]);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
// Self-checking bench for seg_scan_display with a short scan counter.
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_seg_scan_display;

  localparam int RB = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Load;
  logic [12:0] NumberA;
  logic [12:0] NumberB;
  logic        Busy,   busyNb;
  logic [6:0]  out7,   out7Nb;
  logic [7:0]  en_out, enNb;

  seg_scan_display #(.REFRESH_BITS(RB), .BLANK_LEADING(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load), .NumberA(NumberA), .NumberB(NumberB),
    .Busy(Busy), .out7(out7), .en_out(en_out)
  );

  seg_scan_display #(.REFRESH_BITS(RB), .BLANK_LEADING(1'b0)) dutNb (
    .Clk(Clk), .Rst(Rst), .Load(Load), .NumberA(NumberA), .NumberB(NumberB),
    .Busy(busyNb), .out7(out7Nb), .en_out(enNb)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
    logic [31:0] expDigits;   // digits 7..0, one nibble each
  } vec_t;
  vec_t vecs [7];

  logic [31:0] expQ [$];
  bit          pendValid;

  // reload / evidence controls used by watchBusy
  int          reAt1, reAt2;
  logic [12:0] reA1,  reA2;
  logic [6:0]  evSeg [8];
  bit          evMask [8];
  bit          sawEv;
  bit          forbidEn;
  logic [6:0]  forbidSeg;
  bit          sawForbid;

  logic [6:0]  capA [8], capB [8];
  bit          seenA [8], seenB [8];
  bit          oneColdOk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] tbSeg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] expSeg(input logic [31:0] d, input int i, input bit blankEn);
    int base;
    bit zeroAbove;
    base = (i / 4) * 4;
    zeroAbove = 1'b1;
    for (int p = 3; p > i % 4; p--) begin
      if (d[4*(base+p) +: 4] != 4'd0) zeroAbove = 1'b0;
    end
    if (blankEn && (i % 4) != 0 && zeroAbove && d[4*i +: 4] == 4'd0) return 7'b1111111;
    return tbSeg(d[4*i +: 4]);
  endfunction

  function automatic int oneColdIdx(input logic [7:0] e);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m = 8'b1 << i;
      if (e == ~m) return i;
    end
    return -1;
  endfunction

  task automatic captureDisplay();
    int ia, ib;
    for (int i = 0; i < 8; i++) begin
      seenA[i] = 1'b0;
      seenB[i] = 1'b0;
    end
    oneColdOk = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      ia = oneColdIdx(en_out);
      ib = oneColdIdx(enNb);
      if (ia < 0 || ib < 0) oneColdOk = 1'b0;
      if (ia >= 0) begin capA[ia] = out7;   seenA[ia] = 1'b1; end
      if (ib >= 0) begin capB[ib] = out7Nb; seenB[ib] = 1'b1; end
    end
  endtask

  task automatic checkDisplay(input string name, input logic [31:0] e);
    captureDisplay();
    check({name, " anodes"}, 32'(oneColdOk), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s blank d%0d", name, i), {seenA[i], capA[i]}, {1'b1, expSeg(e, i, 1'b1)});
      check($sformatf("%s noblank d%0d", name, i), {seenB[i], capB[i]}, {1'b1, expSeg(e, i, 1'b0)});
    end
  endtask

  // Called at a negedge; returns at the next negedge (Busy sample 1).
  task automatic pulseLoad(input logic [12:0] a, input logic [12:0] b, input logic [31:0] e);
    NumberA = a;
    NumberB = b;
    Load    = 1'b1;
    expQ.push_back(e);
    pendValid = 1'b0;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic watchBusy(output int len);
    int idx;
    len = 0;
    sawEv = 1'b0;
    sawForbid = 1'b0;
    while (Busy && len < 100) begin
      len++;
      Load = 1'b0;
      if (len == reAt1 || len == reAt2) begin
        NumberA = (len == reAt1) ? reA1 : reA2;
        Load = 1'b1;
        if (pendValid) expQ[expQ.size()-1] = {toBcd(int'(NumberB)), toBcd(int'(NumberA))};
        else           expQ.push_back({toBcd(int'(NumberB)), toBcd(int'(NumberA))});
        pendValid = 1'b1;
      end
      if (len == 14) pendValid = 1'b0;
      idx = oneColdIdx(en_out);
      if (idx >= 0) begin
        if (evMask[idx] && out7 == evSeg[idx]) sawEv = 1'b1;
        if (forbidEn && idx == 0 && out7 == forbidSeg) sawForbid = 1'b1;
      end
      @(negedge Clk);
    end
    Load = 1'b0;
  endtask

  task automatic finishCheck(input string name);
    logic [31:0] e;
    if (expQ.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s scoreboard: got 0 entries expected at least 1", name);
      return;
    end
    while (expQ.size() > 1) void'(expQ.pop_front());
    e = expQ.pop_front();
    checkDisplay(name, e);
  endtask

  task automatic setEvidence(input logic [31:0] first);
    for (int i = 0; i < 8; i++) begin
      evSeg[i]  = expSeg(first, i, 1'b1);
      evMask[i] = (i < 3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int busyCnt;
    logic [7:0] m;
    logic [7:0] expEn;
    logic [6:0] expO;

    vecs[0] = '{13'd1234, 13'd8191, 32'h8191_1234};
    vecs[1] = '{13'd7,    13'd0,    32'h0000_0007};
    vecs[2] = '{13'd0,    13'd0,    32'h0000_0000};
    vecs[3] = '{13'd1000, 13'd10,   32'h0010_1000};
    vecs[4] = '{13'd99,   13'd5,    32'h0005_0099};
    vecs[5] = '{13'd8000, 13'd4096, 32'h4096_8000};
    vecs[6] = '{13'd6543, 13'd2109, 32'h2109_6543};

    reAt1 = 0; reAt2 = 0; reA1 = '0; reA2 = '0;
    forbidEn = 1'b0; forbidSeg = 7'h7F; pendValid = 1'b0;
    for (int i = 0; i < 8; i++) begin evSeg[i] = 7'h7F; evMask[i] = 1'b0; end

    // reset and free-running scan
    Rst = 1'b1; Load = 1'b0; NumberA = '0; NumberB = '0;
    repeat (3) @(negedge Clk);
    check("rst Busy", 32'(Busy), 32'd0);
    check("rst out7", 32'(out7), 32'h7F);
    check("rst en_out", 32'(en_out), 32'hFF);
    Rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      m = 8'b1 << ((k - 1) / 2);
      expEn = ~m;
      expO = (((k - 1) / 2) % 4 == 0) ? 7'b0000001 : 7'b1111111;
      check($sformatf("scan en k%0d", k), 32'(en_out), 32'(expEn));
      check($sformatf("scan out7 k%0d", k), 32'(out7), 32'(expO));
      check($sformatf("scan noblank out7 k%0d", k), 32'(out7Nb), 32'h01);
    end
    check("idle Busy", 32'(Busy), 32'd0);

    // table-driven single conversions
    for (int v = 0; v < 7; v++) begin
      pulseLoad(vecs[v].a, vecs[v].b, vecs[v].expDigits);
      watchBusy(len);
      check($sformatf("vec%0d busy len", v), 32'(len), 32'd14);
      finishCheck($sformatf("vec%0d", v));
    end

    // reloads while busy: 100 commits, then 42 (5 is overwritten)
    setEvidence({toBcd(0), toBcd(100)});
    forbidEn = 1'b1; forbidSeg = 7'b0100100;
    reAt1 = 3; reA1 = 13'd5; reAt2 = 6; reA2 = 13'd42;
    pulseLoad(13'd100, 13'd0, {toBcd(0), toBcd(100)});
    watchBusy(len);
    check("pend busy len", 32'(len), 32'd28);
    check("pend first shown", 32'(sawEv), 32'd1);
    check("pend 5 shown", 32'(sawForbid), 32'd0);
    finishCheck("pend final");
    forbidEn = 1'b0;

    // load in the COMMIT cycle chains straight into a second conversion
    setEvidence({toBcd(0), toBcd(305)});
    reAt1 = 14; reA1 = 13'd8; reAt2 = 0;
    pulseLoad(13'd305, 13'd0, {toBcd(0), toBcd(305)});
    watchBusy(len);
    check("commit-load busy len", 32'(len), 32'd28);
    check("commit-load first shown", 32'(sawEv), 32'd1);
    finishCheck("commit-load final");
    reAt1 = 0;

    // reset mid-conversion with a pending load waiting
    NumberA = 13'd999; NumberB = 13'd0; Load = 1'b1;
    @(negedge Clk); Load = 1'b0;             // Busy sample 1
    @(negedge Clk);                          // 2
    @(negedge Clk); NumberA = 13'd555; Load = 1'b1;  // 3
    @(negedge Clk); Load = 1'b0;             // 4
    repeat (3) @(negedge Clk);               // 7
    check("pre-rst Busy", 32'(Busy), 32'd1);
    Rst = 1'b1;
    #1;
    check("async rst Busy", 32'(Busy), 32'd0);
    check("async rst out7", 32'(out7), 32'h7F);
    check("async rst en_out", 32'(en_out), 32'hFF);
    @(negedge Clk);
    Rst = 1'b0;
    busyCnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Busy) busyCnt++;
    end
    check("post-rst busy cycles", 32'(busyCnt), 32'd0);
    checkDisplay("post-rst", 32'h0);

    // normal operation resumes
    pulseLoad(13'd4321, 13'd1, {toBcd(1), toBcd(4321)});
    watchBusy(len);
    check("recover busy len", 32'(len), 32'd14);
    finishCheck("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
